// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared external memory bus between instruction fetch and data access.
// Also merges stage stall requests into the pipeline stall vector.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        id_stallreq,
  input  logic        ex_stallreq,
  output logic [5:0]  stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] D_BUS = 2'd1;
  localparam logic [1:0] I_BUS = 2'd2;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic        dvalid_q, dvalid_d;
  logic        ivalid_q, ivalid_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [7:0]  wcnt_q, wcnt_d;

  logic data_pend;
  logic fetch_pend;

  assign data_pend  = mem_req & ~dvalid_q;
  assign fetch_pend = if_req & ~ivalid_q;

  always_comb begin
    stall = '0;
    if (!reset) begin
      if (data_pend)   stall = stall | 6'b011111;
      if (ex_stallreq) stall = stall | 6'b001111;
      if (id_stallreq) stall = stall | 6'b000111;
      if (fetch_pend)  stall = stall | 6'b000011;
    end
  end

  // Buffered words drop as soon as their consuming register advances; a
  // completing access in the same cycle re-arms the flag.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = 1'b0;
    dvalid_d    = dvalid_q & stall[4];
    ivalid_d    = ivalid_q & stall[1];
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    wcnt_d      = wcnt_q;
    case (state_q)
      IDLE: begin
        if (data_pend) begin
          state_d     = D_BUS;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          wcnt_d      = '0;
        end else if (fetch_pend) begin
          state_d    = I_BUS;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = if_addr;
          wcnt_d     = '0;
        end
      end
      D_BUS, I_BUS: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (state_q == D_BUS) begin
            dvalid_d = 1'b1;
            if (!bus_we_q) mem_rdata_d = bus_rdata;
          end else begin
            ivalid_d  = 1'b1;
            if_inst_d = bus_rdata;
          end
        end else if (wcnt_q == WCNT_LAST) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == D_BUS) begin
            dvalid_d    = 1'b1;
            mem_rdata_d = '0;
          end else begin
            ivalid_d  = 1'b1;
            if_inst_d = '0;
          end
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      dvalid_q    <= 1'b0;
      ivalid_q    <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      wcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
      dvalid_q    <= dvalid_d;
      ivalid_q    <= ivalid_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err   = bus_err_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a transaction-level model is checked every cycle,
// and directed scenarios add hand-computed literal expectations.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        id_stallreq;
  logic        ex_stallreq;
  logic [5:0]  stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .id_stallreq(id_stallreq), .ex_stallreq(ex_stallreq), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Stall is a prefix of stages ending at the deepest stage anyone needs held.
  function automatic logic [5:0] exp_stall(input logic rst, input logic dp, input logic ex,
                                           input logic id, input logic fp);
    int unsigned depth;
    depth = 0;
    if (rst) return 6'd0;
    if (fp) depth = 2;
    if (id) depth = 3;
    if (ex) depth = 4;
    if (dp) depth = 5;
    return 6'((1 << depth) - 1);
  endfunction

  // Transaction-level model: one outstanding access, two one-word buffers.
  bit          m_valid = 1'b0;
  bit          m_busy, m_side_data, m_we, m_err, m_dfull, m_ifull;
  logic [31:0] m_addr, m_wdata, m_inst, m_rdata;
  int unsigned m_high;
  bit          md_dp, md_fp, nd, ni;
  logic [5:0]  md_s;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_busy = 1'b0; m_err = 1'b0; m_dfull = 1'b0; m_ifull = 1'b0;
      m_inst = '0; m_rdata = '0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_high = 0;
    end else if (m_valid) begin
      md_dp = mem_req && !m_dfull;
      md_fp = if_req && !m_ifull;
      md_s  = exp_stall(1'b0, md_dp, ex_stallreq, id_stallreq, md_fp);
      nd = m_dfull && md_s[4];
      ni = m_ifull && md_s[1];
      m_err = 1'b0;
      if (!m_busy) begin
        if (md_dp) begin
          m_busy = 1'b1; m_side_data = 1'b1; m_high = 0;
          m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
        end else if (md_fp) begin
          m_busy = 1'b1; m_side_data = 1'b0; m_high = 0;
          m_addr = if_addr; m_we = 1'b0;
        end
      end else begin
        m_high++;
        if (bus_ack) begin
          m_busy = 1'b0;
          if (m_side_data) begin nd = 1'b1; if (!m_we) m_rdata = bus_rdata; end
          else begin ni = 1'b1; m_inst = bus_rdata; end
        end else if (m_high == TO) begin
          m_busy = 1'b0; m_err = 1'b1;
          if (m_side_data) begin nd = 1'b1; m_rdata = '0; end
          else begin ni = 1'b1; m_inst = '0; end
        end
      end
      m_dfull = nd;
      m_ifull = ni;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_stall", 32'(stall),
          32'(exp_stall(reset, mem_req && !m_dfull, ex_stallreq, id_stallreq, if_req && !m_ifull)));
      chk("m_bus_req", 32'(bus_req), 32'(m_busy));
      chk("m_bus_err", 32'(bus_err), 32'(m_err));
      chk("m_if_inst", if_inst, m_inst);
      chk("m_mem_rdata", mem_rdata, m_rdata);
      if (m_busy) begin
        chk("m_bus_addr", bus_addr, m_addr);
        chk("m_bus_we", 32'(bus_we), 32'(m_we));
        if (m_we) chk("m_bus_wdata", bus_wdata, m_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; id_stallreq = 1'b0; ex_stallreq = 1'b0;
    bus_ack = 1'b0; bus_rdata = '0;

    // Reset and idle
    step; mid;
    chk("rst_stall_during", 32'(stall), 32'd0);
    step; reset = 1'b0;
    mid;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // ID stall alone
    step; id_stallreq = 1'b1;
    mid; chk("id_stall", 32'(stall), 32'h07);
    step; id_stallreq = 1'b0;

    // Zero-wait load
    step; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    mid; chk("ld_c0_stall", 32'(stall), 32'h1F);
    step; bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    mid; chk("ld_c1_bus_req", 32'(bus_req), 32'd1);
    chk("ld_c1_addr", bus_addr, 32'h100);
    chk("ld_c1_stall", 32'(stall), 32'h1F);
    step; bus_ack = 1'b0;
    mid; chk("ld_c2_rdata", mem_rdata, 32'hDEADBEEF);
    chk("ld_c2_stall", 32'(stall), 32'h00);
    chk("ld_c2_bus_req", 32'(bus_req), 32'd0);
    step; mem_req = 1'b0;

    // Store and fetch together: store first, then fetch after a gap
    step; if_req = 1'b1; if_addr = 32'h400;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h12345678;
    mid; chk("sf_c0_stall", 32'(stall), 32'h1F);
    step; bus_ack = 1'b1; bus_rdata = 32'h0BAD0BAD;
    mid; chk("sf_c1_we", 32'(bus_we), 32'd1);
    chk("sf_c1_wdata", bus_wdata, 32'h12345678);
    chk("sf_c1_addr", bus_addr, 32'h200);
    step; bus_ack = 1'b0;
    mid; chk("sf_c2_gap", 32'(bus_req), 32'd0);
    chk("sf_c2_stall", 32'(stall), 32'h03);
    chk("sf_c2_rdata_kept", mem_rdata, 32'hDEADBEEF);
    step; mem_req = 1'b0; mem_we = 1'b0;
    ex_stallreq = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h24020005;
    mid; chk("sf_c3_fetch_req", 32'(bus_req), 32'd1);
    chk("sf_c3_fetch_addr", bus_addr, 32'h400);
    chk("sf_c3_fetch_we", 32'(bus_we), 32'd0);

    // Fetched word held while EX stalls
    step; bus_ack = 1'b0;
    mid; chk("hold_c4_inst", if_inst, 32'h24020005);
    chk("hold_c4_stall", 32'(stall), 32'h0F);
    chk("hold_c4_bus_req", 32'(bus_req), 32'd0);
    step;
    mid; chk("hold_c5_bus_req", 32'(bus_req), 32'd0);
    chk("hold_c5_inst", if_inst, 32'h24020005);
    step; ex_stallreq = 1'b0;
    mid; chk("hold_c6_stall", 32'(stall), 32'h00);
    chk("hold_c6_bus_req", 32'(bus_req), 32'd0);
    step;
    mid; chk("hold_c7_stall", 32'(stall), 32'h03);
    chk("hold_c7_bus_req", 32'(bus_req), 32'd0);
    step; bus_ack = 1'b1; bus_rdata = 32'h00000013;
    mid; chk("hold_c8_bus_req", 32'(bus_req), 32'd1);
    step; bus_ack = 1'b0; if_req = 1'b0;
    mid; chk("hold_c9_inst", if_inst, 32'h00000013);
    step;

    // Load with no ack: timeout abort
    step; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
    for (int i = 1; i <= 4; i++) begin
      step;
      mid; chk($sformatf("to_c%0d_bus_req", i), 32'(bus_req), 32'd1);
      chk($sformatf("to_c%0d_err", i), 32'(bus_err), 32'd0);
    end
    step;
    mid; chk("to_c5_err", 32'(bus_err), 32'd1);
    chk("to_c5_bus_req", 32'(bus_req), 32'd0);
    chk("to_c5_rdata", mem_rdata, 32'd0);
    chk("to_c5_stall", 32'(stall), 32'h00);
    step; mem_req = 1'b0;
    mid; chk("to_c6_err", 32'(bus_err), 32'd0);

    // Reset in the second D_BUS cycle, late ack ignored
    step; mem_req = 1'b1; mem_addr = 32'h500;
    step;
    mid; chk("rm_c1_bus_req", 32'(bus_req), 32'd1);
    step; reset = 1'b1;
    mid; chk("rm_c2_stall", 32'(stall), 32'h00);
    step; reset = 1'b0; mem_req = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    mid; chk("rm_c3_bus_req", 32'(bus_req), 32'd0);
    step; bus_ack = 1'b0;
    mid; chk("rm_c4_rdata", mem_rdata, 32'd0);
    chk("rm_c4_bus_req", 32'(bus_req), 32'd0);
    step; step;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus between instruction fetch (IF) and data access (MEM). It sequences each access through a req/ack handshake with a timeout, and buffers the returned word until the consuming pipeline register captures it. It also merges all stage stall requests into the 6-bit `stall` vector that drives every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).

## Interface

Parameters:
- `TIMEOUT`, default 16: cycles an access may wait for `bus_ack` before it is aborted (range 2..255).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  IF stage requests an instruction fetch at `if_addr`.
- `if_addr`  in  32  fetch address.
- `if_inst`  out  32  fetched instruction, registered.
- `mem_req`  in  1  MEM stage needs a bus access. Driven from ex_mem write_mem | mem_to_regfile.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  store data.
- `mem_rdata`  out  32  load data, registered.
- `id_stallreq`  in  1  ID stall request (load-use hazard).
- `ex_stallreq`  in  1  EX stall request (multi-cycle op).
- `stall`  out  6  bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB. 1 = Stop. Combinational.
- `bus_req`  out  1  access request, registered.
- `bus_we`  out  1  write strobe, registered.
- `bus_addr`  out  32  address, registered.
- `bus_wdata`  out  32  write data, registered.
- `bus_ack`  in  1  access complete. Sampled only while `bus_req` = 1.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `bus_err`  out  1  one-cycle pulse on timeout abort.

## Operation

- **States:** IDLE, D_BUS, I_BUS. Internal flags `dvalid` and `ivalid`. Wait counter `wcnt` is 8 bits.
- **Pending requests:**
  - data pending = `mem_req` & !`dvalid`
  - fetch pending = `if_req` & !`ivalid`
- **IDLE:**
  - Data pending → D_BUS. Load `bus_addr`/`bus_we`/`bus_wdata` from the mem_* inputs and set `bus_req` = 1.
  - Else fetch pending → I_BUS. `bus_addr` = `if_addr`, `bus_we` = 0, `bus_req` = 1.
  - Data has priority when both are pending.
  - `wcnt` cleared on entry to either bus state.
- **D_BUS / I_BUS:**
  - Bus outputs are held stable until the access ends. An access in progress is never preempted.
  - On `bus_ack`:
    - → IDLE, `bus_req` = 0.
    - D_BUS: set `dvalid`. If the access is a load, `mem_rdata` ← `bus_rdata`; a store leaves `mem_rdata` unchanged.
    - I_BUS: set `ivalid`, `if_inst` ← `bus_rdata`.
  - No ack and `wcnt` = TIMEOUT-1:
    - → IDLE, `bus_req` = 0, `bus_err` = 1 for one cycle.
    - Set the valid flag of the aborted side; its data register ← 0, including on an aborted store.
  - Otherwise `wcnt` += 1.
- **Buffer release:**
  - `dvalid` clears at any edge where `stall[4]` = 0.
  - `ivalid` clears at any edge where `stall[1]` = 0.
- **Stall vector:** `stall` is the OR of these masks:
  - data pending → 011111
  - `ex_stallreq` → 001111
  - `id_stallreq` → 000111
  - fetch pending → 000011
  - `stall[5]` is always 0.
  - While `reset` = 1, `stall` = 000000.
- **Reset values:** state IDLE; `bus_req`, `bus_we`, `bus_err`, `dvalid`, `ivalid` = 0; `bus_addr`, `bus_wdata`, `if_inst`, `mem_rdata`, `wcnt` = 0.

## Timing

- **Zero-wait load** (`bus_ack` in the first D_BUS cycle):
  - cycle 0: IDLE, `mem_req` = 1, stall = 011111.
  - cycle 1: D_BUS, `bus_req` = 1, ack.
  - cycle 2: IDLE, `dvalid` = 1, `mem_rdata` valid, stall[4] = 0. mem_wb captures at the end of cycle 2.
  - The MEM stage occupies 3 cycles.
- **Wait states:** each cycle without ack adds 1 cycle.
- **Bus gap:** `bus_req` is low for at least one cycle between consecutive accesses (IDLE always lasts ≥1 cycle).
- **Fetch waiting behind data:** a fetch pending during D_BUS starts at the IDLE cycle after the data access.
- **Data arriving mid-fetch:** a data request during I_BUS waits for that fetch to complete, then wins in IDLE.
- **Buffered word held under stall:** if `ivalid` = 1 but `stall[1]` = 1 (a deeper stage is stalling), `if_inst` is held and no new fetch starts. The same applies to `dvalid`/`mem_rdata` under `stall[4]`.
- **Timeout:** the abort edge falls TIMEOUT cycles after `bus_req` rises. `bus_err` is high during the following IDLE cycle.
- **Reset mid-access:** `bus_req` is 0 in the cycle after the reset edge. A late `bus_ack` is ignored because `bus_req` = 0.

## Test plan

- Reset, then idle inputs → all outputs 0, `stall` = 000000, `bus_req` = 0.
- Load at 0x0000_0100, ack in 1st D_BUS cycle with rdata 0xDEAD_BEEF → stall 011111 for exactly 2 cycles; `mem_rdata` = 0xDEADBEEF in cycle 2; stall[4] = 0 in cycle 2.
- `if_req` and `mem_req` both rise in the same cycle, store 0x1234_5678 to 0x200 → first bus access is the write (`bus_we` = 1, `bus_wdata` = 0x12345678); fetch follows after a 1-cycle `bus_req` gap.
- Fetch completes (`if_inst` = 0x2402_0005) while `ex_stallreq` = 1 for 3 cycles → `if_inst` held, no new `bus_req`; `ivalid` clears on the first edge with stall[1] = 0.
- TIMEOUT = 4, load with no ack → `bus_req` high for 4 cycles, then `bus_err` pulse, `mem_rdata` = 0, stall released the following cycle.
- Reset asserted in the 2nd D_BUS cycle, ack arrives 1 cycle later → `bus_req` = 0, ack ignored, `mem_rdata` stays 0.
